microwave_btn_gesture_decoder: RTL
==================================

// Module: microwave_btn_gesture_decoder
// PURPOSE
//  Consumes the debounced button level and turns it into one-cycle gesture events: short, double, long, auto-repeat.
//  Sits between the button debouncers and the microwave control FSM (time set / start / cancel keys).
//  The control FSM acts only on these pulses, never on raw levels.
// PARAMETERS
//  TICK_DIV   100_000  clk cycles per timing tick (1 ms at 100 MHz)
//  LONG_T     1000     ticks held in a press before o_long fires
//  REPEAT_T   200      ticks between o_repeat pulses after o_long
//  DOUBLE_T   250      ticks after a short release to wait for a second press; 0 disables double detection
// PORTS
//  clk        in   1  100 MHz system clock
//  reset      in   1  asynchronous, active-high reset
//  i_btn      in   1  debounced button level, 1 = pressed; may be asynchronous to clk
//  o_short    out  1  one-cycle pulse: single short press
//  o_double   out  1  one-cycle pulse: two short presses inside DOUBLE_T
//  o_long     out  1  one-cycle pulse: press held LONG_T ticks
//  o_repeat   out  1  one-cycle pulse every REPEAT_T ticks while held after o_long
//  o_held     out  1  level: FSM in HOLD state (for UI fast-count indication)
// BEHAVIOUR
//  - One clock domain; reset is asynchronous and active-high.
//  - On reset, all outputs are 0, the FSM is in IDLE, and all counters are 0.
//  - Reset mid-gesture aborts it with no pulse. After reset release, a still-pressed button is ignored until released (enter WAIT_REL if btn_s=1).
//  - i_btn passes through a 2-FF synchronizer, giving btn_s. Latency is 2 clk.
//  - Tick: prescaler counts 0..TICK_DIV-1 and asserts tick for 1 clk at TICK_DIV-1. It free-runs and is not reset by the FSM.
//  - tcnt: gesture timer, width $clog2(max(LONG_T,REPEAT_T,DOUBLE_T)+1).
//    - Cleared on every state entry.
//    - Increments on tick and saturates.
//  - All event outputs are registered, 1 clk wide, and mutually exclusive. At most one fires per clk.
//  - FSM transitions:
//    - IDLE: btn_s=1 -> PRESS1.
//    - PRESS1:
//      - btn_s=0 and DOUBLE_T==0 -> o_short, IDLE.
//      - btn_s=0 and DOUBLE_T>0 -> GAP.
//      - tick and tcnt==LONG_T-1 -> o_long, HOLD.
//    - GAP:
//      - btn_s=1 -> PRESS2.
//      - tick and tcnt==DOUBLE_T-1 -> o_short, IDLE.
//    - PRESS2:
//      - btn_s=0 -> o_double, IDLE.
//      - tick and tcnt==LONG_T-1 -> o_double, WAIT_REL. No long or repeat follows.
//    - HOLD:
//      - o_held=1.
//      - tick and tcnt==REPEAT_T-1 -> o_repeat, tcnt cleared.
//      - btn_s=0 -> IDLE with no pulse.
//    - WAIT_REL: btn_s=0 -> IDLE.
//  - Simultaneous events: a btn_s change takes priority over a timer expiry in the same clk.
//  - Event latency: o_short/o_double fire in the clk after btn_s is sampled low. o_short with DOUBLE_T>0 fires DOUBLE_T ticks (±1 tick) after release.
//  - Timing resolution: a gesture measures LONG_T ticks -1/+0, because the tick phase is not aligned to the press.
// STRUCTURE
//  - Shared include microwave_defs.vh holds:
//    - state encoding localparams: IDLE, PRESS1, GAP, PRESS2, HOLD, WAIT_REL (3-bit);
//    - default tick constants.
//  - Sub-module microwave_tick_gen (parameter TICK_DIV; ports clk, reset, o_tick) is reused by the cook timer.
//  - Everything else is one always block for state plus counters and one registered output block.
// TESTING  (TICK_DIV=10, LONG_T=5, REPEAT_T=2, DOUBLE_T=3)
//  1. Press 20 clk, release -> exactly one o_short about 30 clk after release. No other pulses.
//  2. Press 20, release 15, press 20, release -> one o_double on the 2nd release. No o_short.
//  3. Hold 120 clk -> o_long about 50 clk after press, then o_repeat every 20 clk (3 pulses), o_held=1. Release -> nothing further.
//  4. DOUBLE_T=0: press 20, release -> o_short 3 clk after the i_btn fall (2 sync + 1 reg).
//  5. Assert reset while in HOLD with the button still held -> outputs 0 immediately. After reset, no event until release and a new press.
//  6. Release lands on the same clk as the LONG_T expiry tick in PRESS1 -> o_short path (GAP) and no o_long.

Source files
------------

// File: rtl/microwave_btn_gesture_decoder_pkg.sv
// Shared types and default timing constants for the microwave button gesture decoder
// and the tick generator it shares with the cook timer.
package microwave_btn_gesture_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS1   = 3'd1,
        ST_GAP      = 3'd2,
        ST_PRESS2   = 3'd3,
        ST_HOLD     = 3'd4,
        ST_WAIT_REL = 3'd5
    } state_e;

    typedef struct packed {
        logic short_p;
        logic double_p;
        logic long_p;
        logic repeat_p;
    } gesture_t;

    localparam int DEF_TICK_DIV = 100_000;
    localparam int DEF_LONG_T   = 1000;
    localparam int DEF_REPEAT_T = 200;
    localparam int DEF_DOUBLE_T = 250;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/microwave_btn_gesture_decoder_tick_gen.sv
// Free-running prescaler: one-clk tick every TICK_DIV clocks, at count TICK_DIV-1.
module microwave_tick_gen
    import microwave_btn_gesture_decoder_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign o_tick = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = o_tick ? '0 : cnt_q + CW'(1);
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/microwave_btn_gesture_decoder.sv
// Turns the debounced button level into one-cycle short/double/long/repeat pulses
// plus a HOLD level for the UI fast-count indication.
module microwave_btn_gesture_decoder
    import microwave_btn_gesture_decoder_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int LONG_T   = DEF_LONG_T,
    parameter int REPEAT_T = DEF_REPEAT_T,
    parameter int DOUBLE_T = DEF_DOUBLE_T
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_short,
    output logic o_double,
    output logic o_long,
    output logic o_repeat,
    output logic o_held
);

    localparam int TW = $clog2(max3(LONG_T, REPEAT_T, DOUBLE_T) + 1);
    localparam logic [TW-1:0] TCNT_MAX    = '1;
    localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_T - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_T - 1);
    localparam logic [TW-1:0] DOUBLE_LAST = TW'(DOUBLE_T - 1);

    logic          btn_meta_q, btn_s_q;
    logic          tick;
    logic          post_rst_q;
    logic          restart;
    state_e        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    gesture_t      ev_q, ev_d;

    microwave_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .o_tick (tick)
    );

    // Synchronizer resets to "pressed" so a button held across reset lands in WAIT_REL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta_q <= 1'b1;
            btn_s_q    <= 1'b1;
        end else begin
            btn_meta_q <= i_btn;
            btn_s_q    <= btn_meta_q;
        end
    end

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ev_d    = '0;
        restart = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (btn_s_q) state_d = post_rst_q ? ST_WAIT_REL : ST_PRESS1;
            end
            ST_PRESS1: begin
                if (!btn_s_q) begin
                    if (DOUBLE_T == 0) begin
                        ev_d.short_p = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else if (tick && tcnt_q == LONG_LAST) begin
                    ev_d.long_p = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (btn_s_q) begin
                    state_d = ST_PRESS2;
                end else if (tick && tcnt_q == DOUBLE_LAST) begin
                    ev_d.short_p = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_PRESS2: begin
                if (!btn_s_q) begin
                    ev_d.double_p = 1'b1;
                    state_d       = ST_IDLE;
                end else if (tick && tcnt_q == LONG_LAST) begin
                    ev_d.double_p = 1'b1;
                    state_d       = ST_WAIT_REL;
                end
            end
            ST_HOLD: begin
                if (!btn_s_q) begin
                    state_d = ST_IDLE;
                end else if (tick && tcnt_q == REPEAT_LAST) begin
                    ev_d.repeat_p = 1'b1;
                    restart       = 1'b1;
                end
            end
            ST_WAIT_REL: begin
                if (!btn_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q || restart) begin
            tcnt_d = '0;
        end else if (tick && tcnt_q != TCNT_MAX) begin
            tcnt_d = tcnt_q + TW'(1);
        end else begin
            tcnt_d = tcnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tcnt_q     <= '0;
            post_rst_q <= 1'b1;
            ev_q       <= '0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            post_rst_q <= 1'b0;
            ev_q       <= ev_d;
        end
    end

    assign o_short  = ev_q.short_p;
    assign o_double = ev_q.double_p;
    assign o_long   = ev_q.long_p;
    assign o_repeat = ev_q.repeat_p;
    assign o_held   = (state_q == ST_HOLD);

endmodule
